// File: rtl/seq_bin_div_if.sv
// -----------------------------------------------------------------------------
// seq_bin_div_if
// Groups the request/result signals of the sequential binary divider.
//   master : drives start, dividend, divisor; observes the results and flags
//   slave  : the divider itself
// Signals:
//   start     request a division (sampled only while idle)
//   dividend  2*DP_WIDTH-bit unsigned dividend
//   divisor   DP_WIDTH-bit unsigned divisor
//   quotient  DP_WIDTH-bit quotient
//   remainder DP_WIDTH-bit remainder
//   rdy       high while the divider is idle
//   div_zero  sticky zero-divisor flag
//   overflow  sticky quotient-overflow flag
// -----------------------------------------------------------------------------
interface seq_bin_div_if #(
  parameter int DP_WIDTH = 8
);
  logic                    start;
  logic [2*DP_WIDTH-1:0]   dividend;
  logic [DP_WIDTH-1:0]     divisor;
  logic [DP_WIDTH-1:0]     quotient;
  logic [DP_WIDTH-1:0]     remainder;
  logic                    rdy;
  logic                    div_zero;
  logic                    overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, rdy, div_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, rdy, div_zero, overflow
  );
endinterface

// File: rtl/seq_bin_div.sv
// -----------------------------------------------------------------------------
// seq_bin_div
// Restoring shift/subtract divider: a 2*DP_WIDTH-bit dividend by a
// DP_WIDTH-bit divisor, one quotient bit per shift/subtract state pair.
// Moore controller S_idle -> S_check -> (S_shift -> S_sub) x DP_WIDTH -> S_idle.
//
// Ports:
//   clk    rising-edge clock
//   rst_b  asynchronous active-low reset
//   bus    seq_bin_div_if.slave (start, dividend, divisor, quotient,
//          remainder, rdy, div_zero, overflow)
//
// Build option:
//   SEQ_BIN_DIV_CHECK_EN  when defined, S_check aborts on a zero divisor
//                         (div_zero) or an oversized quotient (overflow).
//                         When undefined both flags stay 0 and every
//                         division runs the full 2*DP_WIDTH+1 edges.
// -----------------------------------------------------------------------------
module seq_bin_div #(
  parameter int DP_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  seq_bin_div_if.slave bus
);

  localparam int                PW     = $clog2(DP_WIDTH + 1);
  localparam logic [PW-1:0]     P_INIT = PW'(DP_WIDTH);

  typedef enum logic [1:0] {
    S_idle,
    S_check,
    S_shift,
    S_sub
  } state_t;

  state_t                state;
  logic [DP_WIDTH-1:0]   a;      // partial remainder
  logic [DP_WIDTH-1:0]   b;      // divisor
  logic [DP_WIDTH-1:0]   q;      // dividend low half, becomes quotient
  logic                  e;      // bit shifted out of A
  logic [PW-1:0]         p;      // remaining quotient bits
  logic                  div_zero_r;
  logic                  overflow_r;
  logic [DP_WIDTH:0]     diff;

  // Trial subtraction {E,A} - {0,B}; the MSB is the borrow, i.e. negative.
  function automatic logic [DP_WIDTH:0] trial_sub(
    input logic                ext,
    input logic [DP_WIDTH-1:0] acc,
    input logic [DP_WIDTH-1:0] dvs
  );
    trial_sub = {ext, acc} - {1'b0, dvs};
  endfunction

  assign diff = trial_sub(e, a, b);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= S_idle;
      a          <= '0;
      b          <= '0;
      q          <= '0;
      e          <= 1'b0;
      p          <= P_INIT;
      div_zero_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state)
        S_idle: begin
          if (bus.start) begin
            a          <= bus.dividend[2*DP_WIDTH-1:DP_WIDTH];
            q          <= bus.dividend[DP_WIDTH-1:0];
            b          <= bus.divisor;
            e          <= 1'b0;
            p          <= P_INIT;
            div_zero_r <= 1'b0;
            overflow_r <= 1'b0;
            state      <= S_check;
          end
        end
        S_check: begin
`ifdef SEQ_BIN_DIV_CHECK_EN
          // A >= B means the quotient needs more than DP_WIDTH bits.
          if (b == '0) begin
            div_zero_r <= 1'b1;
            state      <= S_idle;
          end else if (a >= b) begin
            overflow_r <= 1'b1;
            state      <= S_idle;
          end else begin
            state      <= S_shift;
          end
`else
          state <= S_shift;
`endif
        end
        S_shift: begin
          {e, a, q} <= {a, q, 1'b0};
          p         <= p - PW'(1);
          state     <= S_sub;
        end
        S_sub: begin
          // Restoring step: only commit the difference when it did not borrow.
          if (!diff[DP_WIDTH]) begin
            a    <= diff[DP_WIDTH-1:0];
            q[0] <= 1'b1;
          end
          e     <= 1'b0;
          state <= (p != '0) ? S_shift : S_idle;
        end
        default: state <= S_idle;
      endcase
    end
  end

  assign bus.rdy       = (state == S_idle);
  assign bus.quotient  = q;
  assign bus.remainder = a;
  assign bus.div_zero  = div_zero_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_seq_bin_div.sv
// -----------------------------------------------------------------------------
// tb_seq_bin_div
// Directed bench for seq_bin_div (DP_WIDTH=8). Stimulus pushes hand-computed
// expected results into a scoreboard queue; a monitor pops one entry each time
// rdy returns high after a busy period and checks quotient, remainder, flags
// and the number of busy cycles. Expectations follow SEQ_BIN_DIV_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_seq_bin_div;

  localparam int W      = 8;
  localparam int LAT_OK = 2 * W + 1;
`ifdef SEQ_BIN_DIV_CHECK_EN
  localparam bit CHK     = 1'b1;
  localparam int LAT_ERR = 1;
`else
  localparam bit CHK     = 1'b0;
  localparam int LAT_ERR = 2 * W + 1;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
    bit           chk_qr;
    string        name;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_b = 1'b1;

  seq_bin_div_if #(.DP_WIDTH(W)) bus ();

  seq_bin_div #(.DP_WIDTH(W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   low_cnt    = 0;
  exp_t e_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: count busy negedges, check one result on each return to idle.
  always @(negedge clk) begin
    if (!rst_b) begin
      low_cnt = 0;
    end else if (!bus.rdy) begin
      low_cnt++;
    end else if (low_cnt > 0) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_op: got result q=0x%0h r=0x%0h, expected no operation",
                 bus.quotient, bus.remainder);
      end else begin
        e_m = sb.pop_front();
        if (e_m.chk_qr) begin
          chk({e_m.name, "_quotient"},  32'(bus.quotient),  32'(e_m.q));
          chk({e_m.name, "_remainder"}, 32'(bus.remainder), 32'(e_m.r));
        end
        chk({e_m.name, "_div_zero"}, 32'(bus.div_zero), 32'(e_m.dz));
        chk({e_m.name, "_overflow"}, 32'(bus.overflow), 32'(e_m.ov));
        chk({e_m.name, "_latency"},  32'(low_cnt),      32'(e_m.lat));
      end
      low_cnt = 0;
    end
  end

  task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                      input logic ov, input int lat, input bit chk_qr, input string name);
    exp_t x;
    x.q = q; x.r = r; x.dz = dz; x.ov = ov; x.lat = lat; x.chk_qr = chk_qr; x.name = name;
    sb.push_back(x);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!bus.rdy && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!bus.rdy) chk("wait_rdy_timeout", 32'(bus.rdy), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                       input logic ov, input int lat, input bit chk_qr, input string name);
    wait_rdy();
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    push(q, r, dz, ov, lat, chk_qr, name);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    #1 rst_b = 1'b0;
    #1;
    chk("rst_rdy",       32'(bus.rdy),       32'd1);
    chk("rst_quotient",  32'(bus.quotient),  32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_div_zero",  32'(bus.div_zero),  32'd0);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    repeat (3) @(negedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk); #1;

    // Valid divisions
    issue(16'd100,   8'd7,    8'd14,  8'd2,   1'b0, 1'b0, LAT_OK, 1'b1, "d100_7");
    drain();
    issue(16'hFEFF,  8'hFF,   8'd255, 8'd254, 1'b0, 1'b0, LAT_OK, 1'b1, "dFEFF_FF");
    drain();
    issue(16'd1000,  8'd10,   8'd100, 8'd0,   1'b0, 1'b0, LAT_OK, 1'b1, "d1000_10");
    drain();
    issue(16'h0700,  8'd8,    8'd224, 8'd0,   1'b0, 1'b0, LAT_OK, 1'b1, "d0700_8");
    drain();
    issue(16'd0,     8'd5,    8'd0,   8'd0,   1'b0, 1'b0, LAT_OK, 1'b1, "d0_5");
    drain();

    // Overflow abort: quotient/remainder keep their loaded values
    issue(16'h0A00,  8'h0A,   8'h00,  8'h0A,  1'b0, CHK,  LAT_ERR, CHK, "ovf");
    drain();
    // Zero divisor abort, flag sticky while idle, cleared by next start
    issue(16'h1234,  8'h00,   8'h34,  8'h12,  CHK,  1'b0, LAT_ERR, CHK, "dz");
    drain();
    repeat (4) @(negedge clk);
    #1;
    chk("dz_sticky", 32'(bus.div_zero), 32'(CHK));
    issue(16'd100,   8'd7,    8'd14,  8'd2,   1'b0, 1'b0, LAT_OK, 1'b1, "dz_clear");
    drain();

    // Reset mid-division
    issue(16'd100,   8'd7,    8'd14,  8'd2,   1'b0, 1'b0, LAT_OK, 1'b1, "aborted");
    repeat (4) @(posedge clk);
    #1 rst_b = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_rdy",       32'(bus.rdy),       32'd1);
    chk("mid_rst_quotient",  32'(bus.quotient),  32'd0);
    chk("mid_rst_remainder", 32'(bus.remainder), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_b = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.rdy), 32'd1);
    issue(16'd100,   8'd7,    8'd14,  8'd2,   1'b0, 1'b0, LAT_OK, 1'b1, "post_rst");
    drain();

    // Back-to-back with start held high, then busy pulses ignored
    wait_rdy();
    bus.dividend = 16'd100;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    push(8'd14, 8'd2, 1'b0, 1'b0, LAT_OK, 1'b1, "b2b_first");
    @(posedge clk); #1;
    bus.dividend = 16'd255;
    bus.divisor  = 8'd16;
    push(8'd15, 8'd15, 1'b0, 1'b0, LAT_OK, 1'b1, "b2b_second");
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.rdy && n < 100);
    if (!bus.rdy) chk("b2b_timeout", 32'(bus.rdy), 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.dividend = 16'd50;
    bus.divisor  = 8'd5;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    #1;
    chk("idle_after_busy_pulse", 32'(bus.rdy), 32'd1);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_bin_div.md
SEQ_BIN_DIV -- requirements
Module: seq_bin_div

Interface
REQ-001 SHALL have parameter DP_WIDTH, default 8, which sets the divisor, quotient and remainder width; the dividend is 2*DP_WIDTH bits.
REQ-002 SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-003 SHALL have port rst_b, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in S_idle.
REQ-005 SHALL have port dividend, input, 2*DP_WIDTH bits: unsigned dividend; sampled on the edge that accepts start.
REQ-006 SHALL have port divisor, input, DP_WIDTH bits: unsigned divisor; sampled on the same edge.
REQ-007 SHALL have port quotient, output, DP_WIDTH bits: quotient register Q.
REQ-008 SHALL have port remainder, output, DP_WIDTH bits: partial-remainder register A.
REQ-009 SHALL have port rdy, output, 1 bit: high exactly when in S_idle.
REQ-010 SHALL have port div_zero, output, 1 bit: sticky error flag for a zero divisor.
REQ-011 SHALL have port overflow, output, 1 bit: sticky error flag for a quotient that does not fit in DP_WIDTH bits.

Function
REQ-012 SHALL use a Moore controller with states S_idle, S_check, S_shift and S_sub; rdy and all control strobes SHALL be decoded from the state.
REQ-013 SHALL, in S_idle with start=1, load A=dividend[2W-1:W], Q=dividend[W-1:0], B=divisor, E=0 and P=DP_WIDTH, clear div_zero and overflow, and move to S_check.
REQ-014 SHALL ignore start in every state except S_idle.
REQ-015 SHALL, in S_check, go to S_idle and set div_zero if B==0.
REQ-016 SHALL, in S_check, otherwise go to S_idle and set overflow if A>=B.
REQ-017 SHALL, in S_check when neither error applies, go to S_shift.
REQ-018 SHALL, in S_shift, shift {E,A,Q} left by 1 with 0 into Q[0], decrement P and go to S_sub.
REQ-019 SHALL, in S_sub, compute the (W+1)-bit value {E,A}-{0,B}; if it is non-negative, load A with its low W bits and set Q[0]=1, otherwise leave A and Q[0] unchanged (restoring division).
REQ-020 SHALL, in S_sub, clear E, then go to S_shift if P!=0, else go to S_idle.
REQ-021 SHALL hold P to ceil(log2(DP_WIDTH+1)) bits.
REQ-022 SHALL reach rdy=1 exactly 2*DP_WIDTH+1 rising edges after the start-accepting edge for a valid division, and exactly 1 edge after it for an error abort.
REQ-023 SHALL hold quotient and remainder stable in S_idle until the next accepted start; their values during a division are intermediate and unspecified to the user.
REQ-024 SHALL accept a start held high at completion on the first S_idle edge, giving back-to-back operations.
REQ-025 SHALL, on an error abort, leave quotient and remainder at their loaded values.

Reset
REQ-026 SHALL, on rst_b low, immediately force state=S_idle, A=B=Q=0, E=0, P=DP_WIDTH and div_zero=overflow=0.
REQ-027 SHALL therefore drive, during reset, rdy=1, quotient=0, remainder=0, div_zero=0 and overflow=0.
REQ-028 SHALL, on rst_b asserted mid-division, abandon the operation with no partial result retained; after release it SHALL wait in S_idle for start.

Configuration
REQ-029 SHALL gate operand checking with the macro SEQ_BIN_DIV_CHECK_EN.
REQ-030 SHALL, with SEQ_BIN_DIV_CHECK_EN defined, behave as REQ-015/REQ-016.
REQ-031 SHALL, without SEQ_BIN_DIV_CHECK_EN, tie div_zero=overflow=0 and have S_check always go to S_shift; latency is then always 2*DP_WIDTH+1, and results for invalid operands are deterministic but undefined.

Verification (DP_WIDTH=8)
REQ-032 SHALL cover: dividend=100, divisor=7 -> quotient=14, remainder=2, no flags, rdy high 17 edges after start.
REQ-033 SHALL cover: dividend=0xFEFF, divisor=0xFF -> quotient=255, remainder=254; and dividend=1000, divisor=10 -> quotient=100, remainder=0.
REQ-034 SHALL cover: dividend=0x0A00, divisor=0x0A -> overflow=1, rdy high 1 edge after start, quotient=0x00, remainder=0x0A.
REQ-035 SHALL cover: divisor=0 with any dividend -> div_zero=1 when the macro is defined, 0 when it is undefined; a following valid start clears the flag.
REQ-036 SHALL cover: rst_b pulsed low 5 cycles into 100/7 -> rdy=1, outputs 0 at once, and a new 100/7 then yields 14 r 2.
REQ-037 SHALL cover: start held high over two operations (100/7, then 255/16) -> second accepted on the first rdy edge, giving 14 r 2 then 15 r 15; start pulses while busy are ignored.
